move_sequencer: RTL and testbench
=================================

Name: move_sequencer

Overview:
Turn-based move controller sitting between the cursor/click front-end and the board register file. It sequences each player move in order: select own piece, query the move-generation block for its legal-move mask, accept a destination click, check it against the mask, then commit two board writes. It owns the side-to-move state and the highlight mask used by the display.

Parameters:
MOVE_LAT, 1, cycles from driving mg_figure/mg_position to a valid mg_moves (move-generation output is registered)
WHITE_MAX, 6, highest white piece code; codes 1..WHITE_MAX are white, WHITE_MAX+1..12 are black, 0 is empty

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
board  in  4 x [7:0][7:0]  current board piece codes, indexed [row][col]
click_valid  in  1  one-cycle pulse: player clicked a square
click_pos  in  6  clicked square; [2:0] column, [5:3] row
click_ready  out  1  high when a click will be accepted
mg_figure  out  4  piece code presented to move generation
mg_position  out  6  square presented to move generation
mg_moves  in  64  legal-move mask; bit (63 - pos) set means pos is reachable
wr_en  out  1  board write strobe
wr_pos  out  6  board write square
wr_code  out  4  board write piece code
turn  out  1  side to move; 0 = white, 1 = black
sel_valid  out  1  a piece is currently selected
sel_pos  out  6  selected square
highlight  out  64  registered copy of the selected piece's mask; zero when nothing is selected
move_done  out  1  one-cycle pulse after the destination write
illegal  out  1  one-cycle pulse when a click is rejected

Behaviour:
- Clock is clk. Reset is rst, synchronous and active-high.
- On reset:
  - state = IDLE; turn = 0.
  - sel_valid = 0, sel_pos = 0, highlight = 0.
  - wr_en = 0, wr_pos = 0, wr_code = 0.
  - move_done = 0, illegal = 0; mg_figure = 0, mg_position = 0.
- Reset asserted in any state, including mid-commit, aborts with no further writes.
- Own piece: code != 0 and (turn == 0 ? code <= WHITE_MAX : code > WHITE_MAX).
- click_ready = 1 only in IDLE and SELECTED. A click_valid while click_ready = 0 is ignored; no illegal pulse.
- States:
  - IDLE:
    - Click on own piece: latch sel_pos = click_pos and piece = board[row][col]; drive mg_figure/mg_position; clear wait counter; go to QUERY.
    - Click on empty or enemy square: illegal pulses for 1 cycle; stay in IDLE.
  - QUERY: count MOVE_LAT cycles, then sample mg_moves.
    - Mask nonzero: highlight = mask; sel_valid = 1; go to SELECTED.
    - Mask zero: illegal pulses; sel_valid = 0; go to IDLE.
  - SELECTED: mg_figure/mg_position are held stable.
    - Click == sel_pos: deselect; highlight = 0; go to IDLE.
    - Click on another own piece: reselect as in IDLE; go to QUERY.
    - highlight[63 - click_pos] == 1: latch dst = click_pos; go to WR_SRC.
    - Otherwise: illegal pulses; stay in SELECTED.
  - WR_SRC: wr_en = 1, wr_pos = sel_pos, wr_code = 0 for exactly 1 cycle; go to WR_DST.
  - WR_DST: wr_en = 1, wr_pos = dst, wr_code = latched piece for 1 cycle; go to FINISH.
  - FINISH:
    - move_done pulses; turn toggles.
    - sel_valid = 0, highlight = 0; go to IDLE.
- Latency from the destination click to move_done is 3 cycles, as registered outputs: the WR_SRC write is seen at click+1, WR_DST at +2, move_done at +3.
- wr_en is never high outside WR_SRC and WR_DST. A capture overwrites the destination; no special handling is needed.
- The board input is not sampled during the WR states.
- Row/column decode is click_pos[5:3] / click_pos[2:0]. Mask index is 63 - pos, computed in 6 bits with no wrap.

Test Plan:
- Reset, then white clicks pos 52 (white pawn code 1 at row 6, col 4) with mg_moves = bits 19 and 27 set -> after MOVE_LAT cycles sel_valid = 1, sel_pos = 52, highlight = 0x0000_0000_0808_0000.
- From that selection, click 44 -> wr (52, 0) at +1, wr (44, 1) at +2, move_done at +3, turn = 1, highlight = 0.
- Selected at 52, click 43 (mask bit 20 clear) -> illegal pulse, no wr_en, still SELECTED with sel_pos = 52.
- turn = 0, click a black piece (code 7) or an empty square -> illegal pulse, state IDLE, mg outputs unchanged.
- Selected at 52: click 52 -> deselect, highlight = 0. Alternatively click own piece at 54 -> new query with mg_position = 54.
- rst asserted during WR_DST -> no further wr_en, move_done stays 0, turn = 0, all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/move_sequencer.sv
// move_sequencer: sequences select/query/confirm/commit for one player move and owns turn and highlight state
module move_sequencer #(
  parameter int MOVE_LAT  = 1,
  parameter int WHITE_MAX = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0][7:0][3:0]  board,
  input  logic                  click_valid,
  input  logic [5:0]            click_pos,
  output logic                  click_ready,
  output logic [3:0]            mg_figure,
  output logic [5:0]            mg_position,
  input  logic [63:0]           mg_moves,
  output logic                  wr_en,
  output logic [5:0]            wr_pos,
  output logic [3:0]            wr_code,
  output logic                  turn,
  output logic                  sel_valid,
  output logic [5:0]            sel_pos,
  output logic [63:0]           highlight,
  output logic                  move_done,
  output logic                  illegal
);
  typedef enum logic [2:0] {IDLE, QUERY, SELECTED, WR_SRC, WR_DST, FINISH} state_t;
  localparam int CW = $clog2(MOVE_LAT + 2);
  localparam logic [3:0] WMAX = 4'(WHITE_MAX);
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [3:0] piece, piece_d, code, mg_figure_d, wr_code_d;
  logic [5:0] dst, dst_d, mg_position_d, wr_pos_d, sel_pos_d;
  logic [63:0] highlight_d;
  logic turn_d, sel_valid_d, wr_en_d, move_done_d, illegal_d, own;
  assign code = board[click_pos[5:3]][click_pos[2:0]];
  assign own = code != 4'd0 && (turn ? code > WMAX : code <= WMAX);
  assign click_ready = state == IDLE || state == SELECTED;
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    piece_d = piece;
    dst_d = dst;
    turn_d = turn;
    sel_valid_d = sel_valid;
    sel_pos_d = sel_pos;
    highlight_d = highlight;
    mg_figure_d = mg_figure;
    mg_position_d = mg_position;
    wr_en_d = 1'b0;
    wr_pos_d = wr_pos;
    wr_code_d = wr_code;
    move_done_d = 1'b0;
    illegal_d = 1'b0;
    case (state)
      IDLE: illegal_d = click_valid && !own;
      QUERY:
        if (cnt == CW'(MOVE_LAT)) begin
          highlight_d = mg_moves;
          sel_valid_d = |mg_moves;
          illegal_d = ~|mg_moves;
          state_d = |mg_moves ? SELECTED : IDLE;
        end else cnt_d = cnt + CW'(1);
      SELECTED:
        if (click_valid && click_pos == sel_pos) begin
          state_d = IDLE;
          sel_valid_d = 1'b0;
          highlight_d = '0;
        end else if (click_valid && !own && highlight[6'd63 - click_pos]) begin
          dst_d = click_pos;
          state_d = WR_SRC;
          wr_en_d = 1'b1;
          wr_pos_d = sel_pos;
          wr_code_d = 4'd0;
        end else illegal_d = click_valid && !own;
      WR_SRC: begin
        state_d = WR_DST;
        wr_en_d = 1'b1;
        wr_pos_d = dst;
        wr_code_d = piece;
      end
      WR_DST: begin
        state_d = FINISH;
        move_done_d = 1'b1;
        turn_d = ~turn;
        sel_valid_d = 1'b0;
        highlight_d = '0;
      end
      default: state_d = IDLE;
    endcase
    // own-piece click (other than the current selection) starts a fresh query
    if (click_valid && click_ready && own && !(state == SELECTED && click_pos == sel_pos)) begin
      sel_pos_d = click_pos;
      piece_d = code;
      mg_figure_d = code;
      mg_position_d = click_pos;
      cnt_d = '0;
      sel_valid_d = 1'b0;
      highlight_d = '0;
      state_d = QUERY;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      piece <= '0;
      dst <= '0;
      turn <= 1'b0;
      sel_valid <= 1'b0;
      sel_pos <= '0;
      highlight <= '0;
      mg_figure <= '0;
      mg_position <= '0;
      wr_en <= 1'b0;
      wr_pos <= '0;
      wr_code <= '0;
      move_done <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      piece <= piece_d;
      dst <= dst_d;
      turn <= turn_d;
      sel_valid <= sel_valid_d;
      sel_pos <= sel_pos_d;
      highlight <= highlight_d;
      mg_figure <= mg_figure_d;
      mg_position <= mg_position_d;
      wr_en <= wr_en_d;
      wr_pos <= wr_pos_d;
      wr_code <= wr_code_d;
      move_done <= move_done_d;
      illegal <= illegal_d;
    end
  end
endmodule

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer: directed plan plus random clicks checked against a move-level game model
module tb_move_sequencer;
  localparam int MOVE_LAT = 1;
  localparam int WHITE_MAX = 6;
  logic clk = 0, rst = 1, click_valid = 0;
  logic [7:0][7:0][3:0] board;
  logic [5:0] click_pos = 0;
  logic [63:0] mg_moves = 0;
  logic click_ready, wr_en, turn, sel_valid, move_done, illegal;
  logic [3:0] mg_figure, wr_code;
  logic [5:0] mg_position, wr_pos, sel_pos;
  logic [63:0] highlight;
  logic [63:0] masks [64];
  int checks = 0, errors = 0;
  bit m_turn = 0, m_sel = 0;
  logic [5:0] m_pos = 0;
  logic [3:0] m_piece = 0;
  logic [63:0] m_hl = 0;

  move_sequencer #(.MOVE_LAT(MOVE_LAT), .WHITE_MAX(WHITE_MAX)) dut (
    .clk(clk), .rst(rst), .board(board), .click_valid(click_valid), .click_pos(click_pos),
    .click_ready(click_ready), .mg_figure(mg_figure), .mg_position(mg_position), .mg_moves(mg_moves),
    .wr_en(wr_en), .wr_pos(wr_pos), .wr_code(wr_code), .turn(turn), .sel_valid(sel_valid),
    .sel_pos(sel_pos), .highlight(highlight), .move_done(move_done), .illegal(illegal));

  always #5 clk = ~clk;
  always @(posedge clk) mg_moves <= masks[mg_position];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_own(input int c, input bit t);
    return c != 0 && (t ? c > WHITE_MAX : c <= WHITE_MAX);
  endfunction

  function automatic logic [3:0] sq(input int p);
    return board[p / 8][p % 8];
  endfunction

  task automatic click(input logic [5:0] p);
    logic [3:0] c;
    c = sq(p);
    click_pos = p;
    click_valid = 1;
    step();
    click_valid = 0;
    if (is_own(c, m_turn) && !(m_sel && p == m_pos)) begin
      check("q_mgpos", mg_position, p);
      check("q_mgfig", mg_figure, c);
      check("q_ready", click_ready, 0);
      check("q_selv", sel_valid, 0);
      click_pos = 6'($urandom);
      click_valid = 1;
      step();
      click_valid = 0;
      check("q_ignore", illegal, 0);
      repeat (MOVE_LAT) step();
      m_pos = p;
      m_piece = c;
      m_sel = masks[p] != 0;
      m_hl = masks[p];
      check("q_illegal", illegal, !m_sel);
    end else if (m_sel && p == m_pos) begin
      m_sel = 0;
      m_hl = 0;
      check("desel_ill", illegal, 0);
    end else if (m_sel && m_hl[63 - int'(p)]) begin
      check("src_en", wr_en, 1);
      check("src_pos", wr_pos, m_pos);
      check("src_code", wr_code, 0);
      step();
      check("dst_en", wr_en, 1);
      check("dst_pos", wr_pos, p);
      check("dst_code", wr_code, m_piece);
      step();
      check("done", move_done, 1);
      check("done_wr", wr_en, 0);
      board[m_pos / 8][m_pos % 8] = 0;
      board[p / 8][p % 8] = m_piece;
      m_turn = !m_turn;
      m_sel = 0;
      m_hl = 0;
      step();
      check("done_end", move_done, 0);
    end else begin
      check("ill_pulse", illegal, 1);
      check("ill_wr", wr_en, 0);
    end
    check("sel_valid", sel_valid, m_sel);
    check("highlight", highlight, m_hl);
    check("turn", turn, m_turn);
    check("ready", click_ready, 1);
    if (m_sel) check("sel_pos", sel_pos, m_pos);
    step();
    check("pulse_end", {illegal, move_done, wr_en}, 0);
  endtask

  function automatic logic [5:0] pick();
    int r, s;
    r = $urandom_range(99);
    s = $urandom_range(63);
    if (m_sel && r < 50)
      for (int k = 0; k < 64; k++) if (m_hl[63 - (s + k) % 64]) return 6'((s + k) % 64);
    if (r < 80)
      for (int k = 0; k < 64; k++) if (is_own(sq((s + k) % 64), m_turn)) return 6'((s + k) % 64);
    if (m_sel && r < 88) return m_pos;
    return 6'(s);
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) begin
      masks[i] = ($urandom_range(4) == 0) ? 64'd0 :
                 {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      board[i / 8][i % 8] = i < 8 ? 4'(8 + i % 5) : i < 16 ? 4'd7 : i >= 56 ? 4'(2 + i % 5) : i >= 48 ? 4'd1 : 4'd0;
    end
    masks[52] = 64'h0000_0000_0808_0000;
    masks[54] = 64'd1 << 17;
    masks[8] = 64'd1 << 47;
    step();
    step();
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_pos", wr_pos, 0);
    check("rst_wr_code", wr_code, 0);
    check("rst_turn", turn, 0);
    check("rst_sel", {sel_valid, sel_pos}, 0);
    check("rst_hl", highlight, 0);
    check("rst_pulses", {move_done, illegal}, 0);
    check("rst_mg", {mg_figure, mg_position}, 0);
    check("rst_ready", click_ready, 1);
    rst = 0;
    step();
    click(8);
    click(36);
    check("ill_mg_kept", {mg_figure, mg_position}, 0);
    click(52);
    check("sel52_hl", highlight, 64'h0000_0000_0808_0000);
    check("sel52_pos", sel_pos, 52);
    click(43);
    click(52);
    click(52);
    click(54);
    check("resel_mgpos", mg_position, 54);
    click(52);
    click(44);
    check("turn_black", turn, 1);
    click(8);
    click_pos = 16;
    click_valid = 1;
    step();
    click_valid = 0;
    check("ab_src", {wr_en, wr_pos}, {1'b1, 6'd8});
    step();
    check("ab_dst", {wr_en, wr_pos}, {1'b1, 6'd16});
    rst = 1;
    step();
    rst = 0;
    check("ab_wr", {wr_en, wr_pos, wr_code}, 0);
    check("ab_done", move_done, 0);
    check("ab_turn", turn, 0);
    check("ab_sel", {sel_valid, sel_pos, highlight}, 0);
    check("ab_mg", {mg_figure, mg_position, illegal}, 0);
    step();
    check("ab_after", {wr_en, move_done}, 0);
    m_turn = 0;
    m_sel = 0;
    m_hl = 0;
    for (int n = 0; n < 300; n++) click(pick());
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
